// File: rtl/deser32_pkg.sv
// Shared definitions for the 32-bit deserializer: word/counter widths and FSM state encodings.
// The state PAR is only reachable when DESER32_PARITY_EN is defined.
package deser32_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10
  } state_e;

endpackage

// File: rtl/_counter5_ce.sv
// 5-bit up counter with asynchronous active-low reset, synchronous clear and count enable.
// Wraps 31 -> 0 naturally, which the deserializer relies on at word completion.
module _counter5_ce
  import deser32_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over the enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/_deserializer32.sv
// Serial-to-parallel input stage: collects one bit per s_valid cycle into a 32-bit word.
// Optional feature macro: DESER32_PARITY_EN adds a trailing even-parity bit per frame,
// the PAR state and the parity_err output.
module _deserializer32
  import deser32_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              s_valid,
  input  logic              s_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              busy
`ifdef DESER32_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              busy_q, busy_d;
`ifdef DESER32_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic              accept;
  logic              in_par;
  logic              cnt_en;
  logic              last_bit;
  logic [WORD_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_next;

  assign accept = s_valid & ~clear;
`ifdef DESER32_PARITY_EN
  assign in_par = (state_q == ST_PAR);
`else
  assign in_par = 1'b0;
`endif
  // The parity bit is not a data bit, so it must not advance the counter.
  assign cnt_en   = accept & ~in_par;
  assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));
  assign shifted  = MSB_FIRST ? {shreg_q[WORD_W-2:0], s_data} : {s_data, shreg_q[WORD_W-1:1]};

  _counter5_ce u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (cnt_en),
    .cnt     (bit_cnt)
  );

  // Mirror of the counter's next value so busy can be registered alongside it.
  always_comb begin
    cnt_next = bit_cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (cnt_en) begin
      cnt_next = bit_cnt + 1'b1;
    end
  end

  // FSM next state, shift register and output register updates.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
`ifdef DESER32_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (accept) begin
      case (state_q)
`ifdef DESER32_PARITY_EN
        ST_PAR: begin
          word_d       = shreg_q;
          word_valid_d = 1'b1;
          parity_err_d = ^{shreg_q, s_data};
          shreg_d      = '0;
          state_d      = ST_IDLE;
        end
`endif
        default: begin
          shreg_d = shifted;
          state_d = ST_SHIFT;
          if (last_bit) begin
`ifdef DESER32_PARITY_EN
            state_d = ST_PAR;
`else
            word_d       = shifted;
            word_valid_d = 1'b1;
            state_d      = ST_IDLE;
`endif
          end
        end
      endcase
    end
    busy_d = (cnt_next != '0) || (state_d == ST_PAR);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DESER32_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
`ifdef DESER32_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
`ifdef DESER32_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
